// File: rtl/pipe_stage_buf.sv
// Inter-stage pipeline register with valid/ready handshake, a one-entry skid buffer, flush and exception redirect.
// Optional perf counters (stall_cnt, kill_cnt) are built only when STAGE_PERF_CNT_EN is defined.
module pipe_stage_buf #(
   parameter int unsigned        DATA_W  = 32,
   parameter int unsigned        LANES   = 6,
   parameter int unsigned        PC_LANE = 1,
   parameter logic [DATA_W-1:0]  EXC_PC  = 32'h0000_4180,
   parameter int unsigned        CNT_W   = 16
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [LANES*DATA_W-1:0]   in_data,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [LANES*DATA_W-1:0]   out_data,
   input  logic                      flush,
   input  logic                      req
`ifdef STAGE_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0]          stall_cnt,
   output logic [CNT_W-1:0]          kill_cnt
`endif
);

   localparam int unsigned PW = LANES * DATA_W;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t          state_q;
   logic [PW-1:0]   main_q;
   logic [PW-1:0]   skid_q;
   logic            out_valid_q;
   logic [PW-1:0]   exc_payload;
   logic            in_fire;
   logic            out_fire;

   // Handler bubble: every lane zero except the PC lane.
   always_comb begin
      exc_payload = '0;
      exc_payload[PC_LANE*DATA_W +: DATA_W] = EXC_PC;
   end

   assign in_ready  = (state_q != FULL) && !flush && !req && reset;
   assign in_fire   = in_valid && in_ready;
   assign out_fire  = out_valid_q && out_ready;
   assign out_valid = out_valid_q;
   assign out_data  = main_q;

   // NOTE: state and data registers use non-blocking assignments so every branch
   // samples the pre-edge values of main_q/skid_q/state_q.
   // NOTE: the payload registers are reset as well, so out_data is a known zero
   // after reset rather than whatever the flops powered up with.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= EMPTY;
         out_valid_q <= 1'b0;
         main_q      <= '0;
         skid_q      <= '0;
      end else if (req) begin
         state_q     <= ONE;
         out_valid_q <= 1'b1;
         main_q      <= exc_payload;
         skid_q      <= '0;
      end else if (flush) begin
         state_q     <= EMPTY;
         out_valid_q <= 1'b0;
      end else begin
         unique case (state_q)
            EMPTY: begin
               if (in_fire) begin
                  main_q      <= in_data;
                  state_q     <= ONE;
                  out_valid_q <= 1'b1;
               end
            end
            ONE: begin
               if (in_fire && out_fire) begin
                  main_q <= in_data;
               end else if (in_fire) begin
                  skid_q  <= in_data;
                  state_q <= FULL;
               end else if (out_fire) begin
                  state_q     <= EMPTY;
                  out_valid_q <= 1'b0;
               end
            end
            FULL: begin
               // Skid is never overwritten: in_ready is low while FULL.
               if (out_fire) begin
                  main_q  <= skid_q;
                  state_q <= ONE;
               end
            end
            default: begin
               state_q     <= EMPTY;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

`ifdef STAGE_PERF_CNT_EN
   logic [1:0]       occupancy;
   logic [1:0]       killed;
   logic [CNT_W:0]   kill_sum;
   logic [CNT_W-1:0] stall_q;
   logic [CNT_W-1:0] kill_q;

   // An entry taken downstream on the flush/req cycle was delivered, not killed.
   always_comb begin
      unique case (state_q)
         ONE:     occupancy = 2'd1;
         FULL:    occupancy = 2'd2;
         default: occupancy = 2'd0;
      endcase
      killed   = (req || flush) ? (occupancy - {1'b0, out_fire}) : 2'd0;
      kill_sum = (CNT_W+1)'(kill_q) + (CNT_W+1)'(killed);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_q <= '0;
         kill_q  <= '0;
      end else begin
         if (out_valid_q && !out_ready && (stall_q != {CNT_W{1'b1}}))
            stall_q <= stall_q + 1'b1;
         kill_q <= kill_sum[CNT_W] ? {CNT_W{1'b1}} : kill_sum[CNT_W-1:0];
      end
   end

   assign stall_cnt = stall_q;
   assign kill_cnt  = kill_q;
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Self-checking bench for pipe_stage_buf: queue-based reference model checked every cycle plus directed literal checks.
// Counter checks are compiled in when STAGE_PERF_CNT_EN is defined.
module tb_pipe_stage_buf;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned LANES  = 6;
   localparam int unsigned PW     = LANES * DATA_W;
   localparam int unsigned CNT_W  = 4;
   localparam int          SAT    = (1 << CNT_W) - 1;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [PW-1:0] in_data = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [PW-1:0] out_data;
   logic          flush = 1'b0;
   logic          req = 1'b0;
`ifdef STAGE_PERF_CNT_EN
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] kill_cnt;
`endif

   int total = 0;
   int bad   = 0;

   // Handler bubble written out by hand: lane 1 = 0x4180, all others 0.
   logic [PW-1:0] exc_lit = {32'h0, 32'h0, 32'h0, 32'h0, 32'h0000_4180, 32'h0};

   pipe_stage_buf #(
      .DATA_W (DATA_W),
      .LANES  (LANES),
      .PC_LANE(1),
      .EXC_PC (32'h0000_4180),
      .CNT_W  (CNT_W)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data (out_data),
      .flush    (flush),
      .req      (req)
`ifdef STAGE_PERF_CNT_EN
      ,
      .stall_cnt(stall_cnt),
      .kill_cnt (kill_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [PW-1:0] pl(input logic [31:0] v);
      return {LANES{v}};
   endfunction

   function automatic int sat(input int a);
      return (a > SAT) ? SAT : a;
   endfunction

   // Reference model: the buffer is a FIFO of at most two payloads.
   logic [PW-1:0] mq[$];
   int stall_m = 0;
   int kill_m  = 0;

   always @(posedge clk or negedge reset) begin : model
      bit v, ofire, ifire;
      if (!reset) begin
         mq.delete();
         stall_m = 0;
         kill_m  = 0;
      end else begin
         v     = (mq.size() != 0);
         ofire = v && out_ready;
         ifire = in_valid && (mq.size() < 2) && !flush && !req;
         if (v && !out_ready) stall_m = sat(stall_m + 1);
         if (req || flush) kill_m = sat(kill_m + mq.size() - (ofire ? 1 : 0));
         if (req) begin
            mq.delete();
            mq.push_back(exc_lit);
         end else if (flush) begin
            mq.delete();
         end else begin
            if (ofire) void'(mq.pop_front());
            if (ifire) mq.push_back(in_data);
         end
      end
   end

   always @(negedge clk) begin : compare
      check("in_ready", PW'(in_ready), PW'((mq.size() < 2) && !flush && !req && reset));
      check("out_valid", PW'(out_valid), PW'(mq.size() != 0));
      if (mq.size() != 0) check("out_data", out_data, mq[0]);
`ifdef STAGE_PERF_CNT_EN
      check("stall_cnt", PW'(stall_cnt), PW'(stall_m));
      check("kill_cnt", PW'(kill_cnt), PW'(kill_m));
`endif
   end

   task automatic tick;
      @(posedge clk);
      #2;
   endtask

   initial begin
      repeat (2) tick();
      check("rst_out_valid", PW'(out_valid), PW'(0));
      check("rst_in_ready", PW'(in_ready), PW'(0));
      check("rst_out_data", out_data, '0);
      reset = 1'b1;
      #1;
      check("rel_in_ready", PW'(in_ready), PW'(1));

      // Streaming: one entry per cycle, latency one, no bubbles.
      in_valid  = 1'b1;
      out_ready = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         in_data = pl(32'(k));
         tick();
         check($sformatf("stream_%0d", k), out_data, pl(32'(k)));
         check($sformatf("stream_v_%0d", k), PW'(out_valid), PW'(1));
      end
      in_valid = 1'b0;
      tick();
      check("stream_drain", PW'(out_valid), PW'(0));

      // Backpressure: A, B fill the buffer; A held until consumed, then B.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = pl(32'hA);
      tick();
      in_data = pl(32'hB);
      tick();
      in_data = pl(32'hC);
      #1;
      check("bp_full_in_ready", PW'(in_ready), PW'(0));
      check("bp_hold_a", out_data, pl(32'hA));
      repeat (2) tick();
      check("bp_still_a", out_data, pl(32'hA));
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      check("bp_then_b", out_data, pl(32'hB));
      tick();
      check("bp_empty", PW'(out_valid), PW'(0));

      // Flush while FULL.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = pl(32'h11);
      tick();
      in_data = pl(32'h22);
      tick();
      in_valid = 1'b0;
      flush    = 1'b1;
      #1;
      check("flush_blocks_in", PW'(in_ready), PW'(0));
      tick();
      flush = 1'b0;
      #1;
      check("flush_out_valid", PW'(out_valid), PW'(0));
      check("flush_in_ready", PW'(in_ready), PW'(1));
`ifdef STAGE_PERF_CNT_EN
      check("flush_kill_cnt", PW'(kill_cnt), PW'(2));
`endif

      // req together with flush while ONE: req wins, handler bubble injected.
      in_valid = 1'b1;
      in_data  = pl(32'h33);
      tick();
      in_valid = 1'b0;
      req      = 1'b1;
      flush    = 1'b1;
      tick();
      req   = 1'b0;
      flush = 1'b0;
      check("req_out_valid", PW'(out_valid), PW'(1));
      check("req_bubble", out_data, exc_lit);
`ifdef STAGE_PERF_CNT_EN
      check("req_kill_cnt", PW'(kill_cnt), PW'(3));
`endif
      out_ready = 1'b1;
      tick();
      check("req_drained", PW'(out_valid), PW'(0));

      // Long stall with a valid entry saturates stall_cnt.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = pl(32'h44);
      tick();
      in_valid = 1'b0;
      repeat (20) tick();
      check("stall_hold", out_data, pl(32'h44));
`ifdef STAGE_PERF_CNT_EN
      check("stall_sat", PW'(stall_cnt), PW'(15));
`endif

      // Asynchronous reset in the middle of a FULL transfer.
      in_valid = 1'b1;
      in_data  = pl(32'h55);
      tick();
      in_valid = 1'b0;
      #1;
      check("pre_rst_full", PW'(in_ready), PW'(0));
      reset = 1'b0;
      #1;
      check("async_rst_out_valid", PW'(out_valid), PW'(0));
      check("async_rst_in_ready", PW'(in_ready), PW'(0));
`ifdef STAGE_PERF_CNT_EN
      check("async_rst_stall", PW'(stall_cnt), PW'(0));
      check("async_rst_kill", PW'(kill_cnt), PW'(0));
`endif
      tick();
      reset = 1'b1;
      #1;
      check("post_rst_in_ready", PW'(in_ready), PW'(1));
      check("post_rst_out_valid", PW'(out_valid), PW'(0));

      // Mixed traffic with a flush and a redirect; the model checks every cycle.
      for (int i = 0; i < 48; i++) begin
         in_valid  = (i % 3) != 0;
         out_ready = (i % 4) < 2;
         flush     = (i == 17);
         req       = (i == 29);
         in_data   = pl(32'h100 + 32'(i));
         tick();
      end
      in_valid  = 1'b0;
      flush     = 1'b0;
      req       = 1'b0;
      out_ready = 1'b1;
      repeat (3) tick();
      check("final_empty", PW'(out_valid), PW'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
